// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants and types for the processor front end.
package fetch_stage_pkg;

   localparam int unsigned ADDR_W_DFLT    = 6;
   localparam int unsigned DATA_W_DFLT    = 32;
   localparam logic [31:0] NOP_INSTR_DFLT = 32'h0000_0000;

   localparam int unsigned FETCH_CNT_W   = 16;
   localparam logic [FETCH_CNT_W-1:0] FETCH_CNT_MAX = '1;

   typedef enum logic {
      StRun  = 1'b0,
      StHalt = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
module if_id_reg #(
   parameter int unsigned          ADDR_W    = 6,
   parameter int unsigned          DATA_W    = 32,
   parameter logic [DATA_W-1:0]    NOP_INSTR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              bubble_i,
   input  logic [DATA_W-1:0] instr_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] pc_o
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] instr_d, instr_q;
   logic [ADDR_W-1:0] pc_d, pc_q;

   // Next-state select: bubble, load or hold.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (bubble_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         pc_d    = '0;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end
   end

   // Register with asynchronous reset to a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, RUN/HALT FSM, fetch counter and IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned       ADDR_W    = ADDR_W_DFLT,
   parameter int unsigned       DATA_W    = DATA_W_DFLT,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DFLT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   redirect,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic [ADDR_W-1:0]      imem_addr,
   output logic                   imem_read,
   input  logic [DATA_W-1:0]      imem_instr,
   input  logic                   imem_pc_en,
   output logic                   ifid_valid,
   output logic [DATA_W-1:0]      ifid_instr,
   output logic [ADDR_W-1:0]      ifid_pc,
   output logic                   halted,
   output logic [FETCH_CNT_W-1:0] fetch_cnt
);

   fetch_state_e           state_d, state_q;
   logic [ADDR_W-1:0]      pc_d, pc_q;
   logic [FETCH_CNT_W-1:0] cnt_d, cnt_q;
   logic                   ifid_load, ifid_bubble;

   // Next-state: redirect > stall > halt hold > normal fetch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      if (redirect) begin
         pc_d        = redirect_pc;
         state_d     = StRun;
         ifid_bubble = 1'b1;
      end else if (stall) begin
         ifid_bubble = flush;
      end else if (state_q == StHalt) begin
         ifid_bubble = 1'b1;
      end else if (imem_pc_en) begin
         pc_d = pc_q + ADDR_W'(1);
         if (flush) begin
            ifid_bubble = 1'b1;
         end else begin
            ifid_load = 1'b1;
            if (cnt_q != FETCH_CNT_MAX) begin
               cnt_d = cnt_q + FETCH_CNT_W'(1);
            end
         end
      end else begin
         // End-of-program marker: PC stays pointing at it.
         state_d     = StHalt;
         ifid_bubble = 1'b1;
      end
   end

   // PC, FSM state and fetch counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   if_id_reg #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (ifid_load),
      .bubble_i (ifid_bubble),
      .instr_i  (imem_instr),
      .pc_i     (pc_q),
      .valid_o  (ifid_valid),
      .instr_o  (ifid_instr),
      .pc_o     (ifid_pc)
   );

   assign imem_addr = pc_q;
   assign imem_read = (state_q == StRun);
   assign halted    = (state_q == StHalt);
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-value queue.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, redirect;
   logic [5:0]  redirect_pc;
   logic [5:0]  imem_addr;
   logic        imem_read;
   logic [31:0] imem_instr;
   logic        imem_pc_en;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [5:0]  ifid_pc;
   logic        halted;
   logic [15:0] fetch_cnt;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [5:0]  pc;
      logic        h;
      logic [5:0]  addr;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   // Bench instruction memory: combinational read, X on non-valid words.
   logic [31:0] mem [64];
   logic        en  [64];
   assign imem_pc_en = en[imem_addr];
   assign imem_instr = en[imem_addr] ? mem[imem_addr] : 32'hxxxx_xxxx;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_read   (imem_read),
      .imem_instr  (imem_instr),
      .imem_pc_en  (imem_pc_en),
      .ifid_valid  (ifid_valid),
      .ifid_instr  (ifid_instr),
      .ifid_pc     (ifid_pc),
      .halted      (halted),
      .fetch_cnt   (fetch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Push the expectation, take one edge, then pop and compare.
   task automatic step(input string tag, input logic v, input logic [31:0] instr,
                       input logic [5:0] pc, input logic h, input logic [5:0] addr,
                       input logic [15:0] cnt);
      exp_t e;
      sb.push_back('{v: v, instr: instr, pc: pc, h: h, addr: addr, cnt: cnt});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".valid"}, 32'(ifid_valid), 32'(e.v));
      chk({tag, ".instr"}, ifid_instr, e.instr);
      chk({tag, ".pc"}, 32'(ifid_pc), 32'(e.pc));
      chk({tag, ".halted"}, 32'(halted), 32'(e.h));
      chk({tag, ".addr"}, 32'(imem_addr), 32'(e.addr));
      chk({tag, ".cnt"}, 32'(fetch_cnt), 32'(e.cnt));
      chk({tag, ".read"}, 32'(imem_read), 32'(!e.h));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".valid"}, 32'(ifid_valid), 32'd0);
      chk({tag, ".instr"}, ifid_instr, 32'h0);
      chk({tag, ".pc"}, 32'(ifid_pc), 32'd0);
      chk({tag, ".halted"}, 32'(halted), 32'd0);
      chk({tag, ".addr"}, 32'(imem_addr), 32'd0);
      chk({tag, ".cnt"}, 32'(fetch_cnt), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'hC000_0000 | 32'(i);
         en[i]  = 1'b1;
      end
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      mem[4] = 32'hFFFF_FFFF; en[4] = 1'b0;
      en[8]  = 1'b0;

      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
      #12;
      chk_reset_state("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Straight-line program ending at the marker in word 4.
      step("p0", 1, 32'h11, 0, 0, 1, 1);
      step("p1", 1, 32'h22, 1, 0, 2, 2);
      step("p2", 1, 32'h33, 2, 0, 3, 3);
      step("p3", 1, 32'h44, 3, 0, 4, 4);
      step("p_halt", 0, 32'h0, 0, 1, 4, 4);
      step("p_hold", 0, 32'h0, 0, 1, 4, 4);
      flush = 1'b1;
      step("halt_flush", 0, 32'h0, 0, 1, 4, 4);
      flush = 1'b0;

      // Redirect out of HALT to 5, run to the marker at 8.
      redirect = 1'b1; redirect_pc = 6'd5;
      step("halt_redir", 0, 32'h0, 0, 0, 5, 4);
      redirect = 1'b0;
      step("r5", 1, mem[5], 5, 0, 6, 5);
      step("r6", 1, mem[6], 6, 0, 7, 6);
      step("r7", 1, mem[7], 7, 0, 8, 7);
      step("r_halt", 0, 32'h0, 0, 1, 8, 7);

      // Asynchronous reset pulse between edges while halted.
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("arst");
      @(negedge clk);
      rst_n = 1'b1;
      step("a0", 1, 32'h11, 0, 0, 1, 1);
      step("a1", 1, 32'h22, 1, 0, 2, 2);

      // Stall three edges at PC 2, then stall with flush, then resume.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) step("stall", 1, 32'h22, 1, 0, 2, 2);
      flush = 1'b1;
      step("stall_flush", 0, 32'h0, 0, 0, 2, 2);
      stall = 1'b0; flush = 1'b0;
      step("s2", 1, 32'h33, 2, 0, 3, 3);
      step("s3", 1, 32'h44, 3, 0, 4, 4);
      step("s_halt", 0, 32'h0, 0, 1, 4, 4);

      // Redirect to 10 with stall and flush in the same cycle.
      redirect = 1'b1; redirect_pc = 6'd10; stall = 1'b1; flush = 1'b1;
      step("redir10", 0, 32'h0, 0, 0, 10, 4);
      redirect = 1'b0; stall = 1'b0; flush = 1'b0;
      step("f10", 1, mem[10], 10, 0, 11, 5);
      flush = 1'b1;
      step("run_flush", 0, 32'h0, 0, 0, 12, 5);
      flush = 1'b0;
      step("f12", 1, mem[12], 12, 0, 13, 6);

      // PC wrap from 63 to 0.
      redirect = 1'b1; redirect_pc = 6'd63;
      step("redir63", 0, 32'h0, 0, 0, 63, 6);
      redirect = 1'b0;
      step("f63", 1, mem[63], 63, 0, 0, 7);
      step("wrap0", 1, 32'h11, 0, 0, 1, 8);

      // Reset asserted mid-stall overrides it.
      stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("stall_rst");
      @(negedge clk);
      rst_n = 1'b1; stall = 1'b0;
      step("post_rst", 1, 32'h11, 0, 0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
